// File: rtl/uart_rx_ahb_pkg.sv
// Shared definitions for the UART receive buffer AHB-Lite slave:
// register offsets, AHB encodings, register bit positions and the
// response state type.
package uart_rx_ahb_pkg;

    // Register byte offsets within the slave window
    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_CLEAR  = 8'h0C;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // STATUS bit positions (count occupies [7:0])
    localparam int unsigned STATUS_EMPTY_BIT = 8;
    localparam int unsigned STATUS_FULL_BIT  = 9;
    localparam int unsigned STATUS_OVF_BIT   = 10;

    // CTRL bit positions
    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_OVF_IE_BIT = 1;
    localparam int unsigned CTRL_THRESH_LSB = 8;

    // CLEAR bit positions
    localparam int unsigned CLEAR_FLUSH_BIT = 0;
    localparam int unsigned CLEAR_OVF_BIT   = 1;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_t;

    // Word select of a register offset
    function automatic logic [1:0] reg_sel(input logic [7:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/uart_rx_ahb_buffer_fifo.sv
// Synchronous FIFO for received bytes.
// Ports: HCLK/HRESETN (sync active-low reset), push/din write side,
// pop read side, flush empties the FIFO, dout shows the head entry,
// count/full/empty report occupancy.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETN,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO only lands when a pop frees a slot in the same cycle
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge HCLK) begin
        if (HRESETN && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ahb_buffer.sv
// AHB-Lite MMIO slave buffering UART receive bytes.
// Ports: HCLK/HRESETN (sync active-low reset); RX_DATA/RX_VALID from the
// UART core; AHB-Lite slave HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY
// in, HREADYOUT/HRESP/HRDATA out; IRQ level interrupt.
// Registers: 0x00 DATA (RO, pops), 0x04 STATUS (RO), 0x08 CTRL (RW),
// 0x0C CLEAR (WO). Offsets >= 0x10 give a two-cycle ERROR response.
module uart_rx_ahb_buffer
    import uart_rx_ahb_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 5,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              IRQ
);

    resp_state_t       state, state_next;
    logic              acc, addr_err;
    logic              dp_valid, dp_write;
    logic [1:0]        dp_sel;
    logic              dp_rd, dp_wr;
    logic              pop, flush, clr_ovf, ctrl_wr, ovf_set;
    logic              irq_en, ovf_ie, ovf;
    logic [7:0]        thresh;
    logic [7:0]        head;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic [8:0]        count9, eff_thresh;
    logic              unused;

    assign unused = ^{HSIZE, HWDATA[31:16], HWDATA[7:2], HADDR[1:0]};

    assign acc      = HSEL & HREADY & HTRANS[1];
    assign addr_err = |HADDR[ADDR_W-1:4];

    // Only error-free accesses reach the data phase; errors are handled by the FSM alone
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_sel   <= '0;
        end else begin
            dp_valid <= acc & ~addr_err;
            if (acc) begin
                dp_write <= HWRITE;
                dp_sel   <= HADDR[3:2];
            end
        end
    end

    assign dp_rd   = dp_valid & ~dp_write;
    assign dp_wr   = dp_valid & dp_write;
    assign pop     = dp_rd & (dp_sel == reg_sel(OFF_DATA)) & ~empty;
    assign ctrl_wr = dp_wr & (dp_sel == reg_sel(OFF_CTRL));
    assign flush   = dp_wr & (dp_sel == reg_sel(OFF_CLEAR)) & HWDATA[CLEAR_FLUSH_BIT];
    assign clr_ovf = dp_wr & (dp_sel == reg_sel(OFF_CLEAR)) & HWDATA[CLEAR_OVF_BIT];
    assign ovf_set = RX_VALID & full & ~pop & ~flush;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .push    (RX_VALID),
        .din     (RX_DATA),
        .pop     (pop),
        .flush   (flush),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state  <= RESP_IDLE;
            irq_en <= 1'b0;
            ovf_ie <= 1'b0;
            thresh <= '0;
            ovf    <= 1'b0;
            IRQ    <= 1'b0;
        end else begin
            state <= state_next;
            if (ctrl_wr) begin
                irq_en <= HWDATA[CTRL_IRQ_EN_BIT];
                ovf_ie <= HWDATA[CTRL_OVF_IE_BIT];
                thresh <= HWDATA[CTRL_THRESH_LSB +: 8];
            end
            // A new overflow event outranks a simultaneous clear so it is never lost
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            IRQ <= (irq_en & (count9 >= eff_thresh)) | (ovf_ie & ovf);
        end
    end

    assign count9     = 9'(count);
    assign eff_thresh = (thresh == '0)             ? 9'd1 :
                        (9'(thresh) > 9'(DEPTH))   ? 9'(DEPTH) : 9'(thresh);

    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state)
            RESP_IDLE: begin
                if (acc && addr_err) state_next = RESP_ERR1;
            end
            RESP_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = RESP_ERR2;
            end
            RESP_ERR2: begin
                HRESP      = HRESP_ERROR;
                state_next = (acc && addr_err) ? RESP_ERR1 : RESP_IDLE;
            end
            default: state_next = RESP_IDLE;
        endcase
    end

    always_comb begin
        HRDATA = '0;
        if (dp_rd) begin
            case (dp_sel)
                reg_sel(OFF_DATA):   HRDATA = empty ? 32'h0000_0100 : {24'b0, head};
                reg_sel(OFF_STATUS): begin
                    HRDATA[7:0]              = 8'(count);
                    HRDATA[STATUS_EMPTY_BIT] = empty;
                    HRDATA[STATUS_FULL_BIT]  = full;
                    HRDATA[STATUS_OVF_BIT]   = ovf;
                end
                reg_sel(OFF_CTRL): begin
                    HRDATA[CTRL_IRQ_EN_BIT]         = irq_en;
                    HRDATA[CTRL_OVF_IE_BIT]         = ovf_ie;
                    HRDATA[CTRL_THRESH_LSB +: 8]    = thresh;
                end
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ahb_buffer.sv
// Directed self-checking bench for uart_rx_ahb_buffer (DEPTH=16).
module tb_uart_rx_ahb_buffer;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    // Single-slave bus: the slave's ready feeds back as HREADY
    assign HREADY = HREADYOUT;

    uart_rx_ahb_buffer #(.DEPTH(16), .CNT_W(5), .ADDR_W(8)) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .IRQ       (IRQ)
    );

    task automatic ahb_read(input logic [7:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic ahb_write(input logic [7:0] addr, input logic [31:0] wdata);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = wdata;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge HCLK); #1;
        RX_VALID = 1'b1; RX_DATA = b;
        @(posedge HCLK); #1;
        RX_VALID = 1'b0;
    endtask

    task automatic settle2();
        @(posedge HCLK);
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        HRESETN = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        checks++;
        if ({HREADYOUT, HRESP, IRQ} !== 3'b100 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b resp=%b irq=%b rdata=%h, expected rdy=1 resp=0 irq=0 rdata=0",
                     HREADYOUT, HRESP, IRQ, HRDATA);
        end
        HRESETN = 1'b1;
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL reset_status: got %h, expected %h", d, 32'h100);
        end
        ahb_read(8'h08, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h, expected %h", d, 32'h0);
        end
    endtask

    task automatic test_fifo_basic();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) push_byte(8'(8'h41 + i));
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0003) begin
            errors++; $display("FAIL basic_status3: got %h, expected %h", d, 32'h3);
        end
        for (int i = 0; i < 3; i++) begin
            ahb_read(8'h00, d);
            checks++;
            if (d !== 32'(8'h41 + i)) begin
                errors++; $display("FAIL basic_data%0d: got %h, expected %h", i, d, 32'(8'h41 + i));
            end
        end
        ahb_read(8'h00, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL basic_empty_read: got %h, expected %h", d, 32'h100);
        end
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL basic_status0: got %h, expected %h", d, 32'h100);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0610) begin
            errors++; $display("FAIL ovf_status: got %h, expected %h", d, 32'h610);
        end
        ahb_write(8'h0C, 32'h2);
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0210) begin
            errors++; $display("FAIL ovf_cleared: got %h, expected %h", d, 32'h210);
        end
        for (int i = 0; i < 16; i++) begin
            ahb_read(8'h00, d);
            checks++;
            if (d !== 32'(i)) begin
                errors++; $display("FAIL ovf_data%0d: got %h, expected %h", i, d, 32'(i));
            end
        end
        ahb_read(8'h00, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL ovf_17th_lost: got %h, expected %h", d, 32'h100);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h00;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        RX_VALID = 1'b1; RX_DATA = 8'h90;
        checks++;
        if (HRDATA !== 32'h0000_0080) begin
            errors++; $display("FAIL fullpop_head: got %h, expected %h", HRDATA, 32'h80);
        end
        @(posedge HCLK); #1;
        RX_VALID = 1'b0;
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0210) begin
            errors++; $display("FAIL fullpop_status: got %h, expected %h", d, 32'h210);
        end
        for (int i = 0; i < 16; i++) begin
            ahb_read(8'h00, d);
            checks++;
            if (d !== 32'(8'h81 + i)) begin
                errors++; $display("FAIL fullpop_data%0d: got %h, expected %h", i, d, 32'(8'h81 + i));
            end
        end
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL fullpop_drained: got %h, expected %h", d, 32'h100);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        ahb_write(8'h08, 32'h0000_0301);
        ahb_read(8'h08, d);
        checks++;
        if (d !== 32'h0000_0301) begin
            errors++; $display("FAIL irq_ctrl_rb: got %h, expected %h", d, 32'h301);
        end
        push_byte(8'hA0);
        push_byte(8'hA1);
        @(posedge HCLK); #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++; $display("FAIL irq_below: got %b, expected 0", IRQ);
        end
        push_byte(8'hA2);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++; $display("FAIL irq_latency: got %b, expected 0", IRQ);
        end
        @(posedge HCLK); #1;
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL irq_at_thresh: got %b, expected 1", IRQ);
        end
        ahb_read(8'h00, d);
        checks++;
        if (d !== 32'h0000_00A0) begin
            errors++; $display("FAIL irq_pop_data: got %h, expected %h", d, 32'hA0);
        end
        @(posedge HCLK); #1;
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL irq_pop_lag: got %b, expected 1", IRQ);
        end
        @(posedge HCLK); #1;
        checks++;
        if (IRQ !== 1'b0) begin
            errors++; $display("FAIL irq_after_pop: got %b, expected 0", IRQ);
        end
        // thresh=0 behaves as 1
        ahb_write(8'h08, 32'h0000_0001);
        settle2();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL irq_thresh0: got %b, expected 1", IRQ);
        end
        // thresh=32 clamps to DEPTH
        ahb_write(8'h08, 32'h0000_2001);
        settle2();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++; $display("FAIL irq_thresh32_low: got %b, expected 0", IRQ);
        end
        for (int i = 0; i < 14; i++) push_byte(8'(8'hB0 + i));
        @(posedge HCLK); #1;
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL irq_thresh_clamp: got %b, expected 1", IRQ);
        end
        push_byte(8'hEE);
        ahb_write(8'h08, 32'h0000_0002);
        settle2();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL irq_ovf_ie: got %b, expected 1", IRQ);
        end
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0610) begin
            errors++; $display("FAIL irq_ovf_status: got %h, expected %h", d, 32'h610);
        end
        ahb_write(8'h0C, 32'h0000_0003);
        settle2();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++; $display("FAIL irq_cleared: got %b, expected 0", IRQ);
        end
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL clear_status: got %h, expected %h", d, 32'h100);
        end
        ahb_write(8'h08, 32'h0);
    endtask

    task automatic test_error();
        logic [31:0] d;
        push_byte(8'h55);
        push_byte(8'h66);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h20;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        checks++;
        if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
            errors++; $display("FAIL err_cycle1: got rdy=%b resp=%b, expected rdy=0 resp=1", HREADYOUT, HRESP);
        end
        @(posedge HCLK); #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
            errors++; $display("FAIL err_cycle2: got rdy=%b resp=%b, expected rdy=1 resp=1", HREADYOUT, HRESP);
        end
        @(posedge HCLK); #1;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++; $display("FAIL err_done: got rdy=%b resp=%b, expected rdy=1 resp=0", HREADYOUT, HRESP);
        end
        // Error write carrying a flush pattern must have no effect
        ahb_write(8'h2C, 32'h0000_0003);
        repeat (3) @(posedge HCLK);
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL err_no_effect: got %h, expected %h", d, 32'h2);
        end
        ahb_read(8'h00, d);
        checks++;
        if (d !== 32'h0000_0055) begin
            errors++; $display("FAIL err_data_kept: got %h, expected %h", d, 32'h55);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
        ahb_write(8'h08, 32'h0000_0001);
        settle2();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++; $display("FAIL rstmid_irq_pre: got %b, expected 1", IRQ);
        end
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 8'h00;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        checks++;
        if (HRDATA !== 32'h0000_0066) begin
            errors++; $display("FAIL rstmid_head: got %h, expected %h", HRDATA, 32'h66);
        end
        HRESETN = 1'b0;
        @(posedge HCLK); #1;
        checks++;
        if ({HREADYOUT, HRESP, IRQ} !== 3'b100 || HRDATA !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rdy=%b resp=%b irq=%b rdata=%h, expected rdy=1 resp=0 irq=0 rdata=0",
                     HREADYOUT, HRESP, IRQ, HRDATA);
        end
        HRESETN = 1'b1;
        ahb_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL rstmid_status: got %h, expected %h", d, 32'h100);
        end
        ahb_read(8'h08, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rstmid_ctrl: got %h, expected %h", d, 32'h0);
        end
    endtask

    initial begin
        HRESETN = 1'b0; RX_DATA = '0; RX_VALID = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0;
        test_reset();
        test_fifo_basic();
        test_overflow();
        test_full_pop();
        test_irq();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
